// File: rtl/ram_arbiter.sv
// Arbiter sharing one single-ported data RAM between the load/store unit (m0) and the
// debug/boot loader (m1): round-robin grants, bounded lock, registered read return.

module ram_arbiter_rport #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cap,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata
);
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_cap;
      if (i_cap) r_rdata <= i_data;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
endmodule

module ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);
  localparam int CNT_W = $clog2(MAX_LOCK) + 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_last, r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;

  logic [1:0]             w_req, w_we, w_lock, w_gnt, w_rvalid;
  logic [1:0][ADDR_W-1:0] w_addr;
  logic [1:0][DATA_W-1:0] w_wdata, w_rdata;
  logic                   w_any, w_sel, w_force;

  assign w_req   = {m1_req_i, m0_req_i};
  assign w_we    = {m1_we_i, m0_we_i};
  assign w_lock  = {m1_lock_i, m0_lock_i};
  assign w_addr  = {m1_addr_i, m0_addr_i};
  assign w_wdata = {m1_wdata_i, m0_wdata_i};

  // Grant select; reset low suppresses every grant so no RAM write can slip through.
  always_comb begin
    w_any   = 1'b0;
    w_sel   = 1'b0;
    w_force = 1'b0;
    if (rst_n) begin
      if (r_state == LOCKED && w_req[r_owner]) begin
        w_any   = 1'b1;
        w_force = (r_lock_cnt >= CNT_W'(MAX_LOCK)) && w_req[~r_owner];
        w_sel   = w_force ? ~r_owner : r_owner;
      end else if (w_req == 2'b11) begin
        w_any = 1'b1;
        w_sel = ~r_last;
      end else if (|w_req) begin
        w_any = 1'b1;
        w_sel = w_req[1];
      end
    end
  end

  assign w_gnt       = {w_any & w_sel, w_any & ~w_sel};
  assign m0_gnt_o    = w_gnt[0];
  assign m1_gnt_o    = w_gnt[1];
  assign ram_wr_en_o = w_any & w_we[w_sel];
  assign ram_addr_o  = w_any ? w_addr[w_sel]  : '0;
  assign ram_data_o  = w_any ? w_wdata[w_sel] : '0;

  // The lock counter only advances while the other master is actually being held off.
  always_comb begin
    w_state_nxt    = ARB;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = '0;
    if (w_any && w_lock[w_sel] && !w_force) begin
      w_state_nxt = LOCKED;
      w_owner_nxt = w_sel;
      if (r_state == LOCKED && r_owner == w_sel)
        w_lock_cnt_nxt = r_lock_cnt + CNT_W'(w_req[~w_sel]);
      else
        w_lock_cnt_nxt = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      if (w_any) r_last <= w_sel;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_rport
    ram_arbiter_rport #(.DATA_W(DATA_W)) u_rport (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_cap    (w_gnt[g] & ~w_we[g]),
      .i_data   (ram_data_i),
      .o_rvalid (w_rvalid[g]),
      .o_rdata  (w_rdata[g])
    );
  end

  assign m0_rvalid_o = w_rvalid[0];
  assign m0_rdata_o  = w_rdata[0];
  assign m1_rvalid_o = w_rvalid[1];
  assign m1_rdata_o  = w_rdata[1];
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, per-cycle reference model compare, directed scenarios.

module tb_ram_arbiter;
  localparam int MAXL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_wr_en;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_data_o, ram_data_i;

  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_dat;
  logic [31:0] mem [256];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_wr_en_o(ram_wr_en), .ram_addr_o(ram_addr), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  // RAM: combinational read, write at the edge; a backdoor port preloads words.
  assign ram_data_i = mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    else if (ram_wr_en) mem[ram_addr[9:2]] <= ram_data_o;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who holds a lock, how many contended grants it has had, who went last.
  int          mlast, mlock, mrun, g, nlast, nlock, nrun;
  bit          frc, mrv0, mrv1, nrv0, nrv1, wpend, ppend;
  logic [1:0]  rq;
  logic [31:0] mrd0, mrd1, nrd0, nrd1, wa, wd, pa, pd;
  logic [31:0] shadow [256];
  logic [31:0] ea [2];
  logic [31:0] ed [2];
  logic        ew [2];
  logic        el [2];

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    mlast = 1; mlock = -1; mrun = 0; mrv0 = 0; mrv1 = 0; mrd0 = '0; mrd1 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mlast = 1; mlock = -1; mrun = 0; mrv0 = 0; mrv1 = 0; mrd0 = '0; mrd1 = '0;
      end
      rq = {m1_req, m0_req};
      ea[0] = m0_addr; ea[1] = m1_addr; ed[0] = m0_wdata; ed[1] = m1_wdata;
      ew[0] = m0_we;   ew[1] = m1_we;   el[0] = m0_lock;  el[1] = m1_lock;
      g = -1; frc = 0;
      if (rst_n) begin
        if (mlock >= 0 && rq[mlock]) begin
          if (mrun >= MAXL && rq[1-mlock]) begin g = 1 - mlock; frc = 1; end
          else g = mlock;
        end else if (rq == 2'b11) g = 1 - mlast;
        else if (rq[0]) g = 0;
        else if (rq[1]) g = 1;
      end
      chk("mdl_m0_gnt", 32'(m0_gnt), 32'(g == 0));
      chk("mdl_m1_gnt", 32'(m1_gnt), 32'(g == 1));
      chk("mdl_wr_en", 32'(ram_wr_en), (g >= 0) ? 32'(ew[g]) : 32'd0);
      chk("mdl_ram_addr", ram_addr, (g >= 0) ? ea[g] : 32'd0);
      chk("mdl_ram_data", ram_data_o, (g >= 0) ? ed[g] : 32'd0);
      chk("mdl_m0_rvalid", 32'(m0_rvalid), 32'(mrv0));
      chk("mdl_m1_rvalid", 32'(m1_rvalid), 32'(mrv1));
      chk("mdl_m0_rdata", m0_rdata, mrd0);
      chk("mdl_m1_rdata", m1_rdata, mrd1);
      nrv0 = 0; nrv1 = 0; nrd0 = mrd0; nrd1 = mrd1; wpend = 0;
      nlast = mlast; nlock = -1; nrun = 0;
      if (g >= 0) begin
        nlast = g;
        if (ew[g]) begin wpend = 1; wa = ea[g]; wd = ed[g]; end
        else if (g == 0) begin nrv0 = 1; nrd0 = shadow[ea[0][9:2]]; end
        else begin nrv1 = 1; nrd1 = shadow[ea[1][9:2]]; end
        if (el[g] && !frc) begin
          nrun = (mlock == g) ? mrun + int'(rq[1-g]) : 1;
          nlock = g;
        end
      end
      ppend = pre_we; pa = 32'(pre_idx); pd = pre_dat;
      @(posedge clk);
      if (ppend) shadow[pa[7:0]] = pd;
      if (rst_n) begin
        mlast = nlast; mlock = nlock; mrun = nrun;
        mrv0 = nrv0; mrv1 = nrv1; mrd0 = nrd0; mrd1 = nrd1;
        if (wpend) shadow[wa[9:2]] = wd;
      end
    end
  end

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int k, gi, n0;

  initial begin
    rst_n = 1; idle(); pre_we = 0; pre_idx = '0; pre_dat = '0;
    #1 rst_n = 0;
    step();
    pre_we = 1; pre_idx = 8'h10; pre_dat = 32'hDEADBEEF; step();
    pre_idx = 8'h11; pre_dat = 32'h11111111; step();
    pre_we = 0;
    // requests during reset must not be granted
    m0_req = 1; m0_we = 1; m0_addr = 32'h80; m0_wdata = 32'h55;
    #2;
    chk("rst_m0_gnt", 32'(m0_gnt), 0);
    chk("rst_wr_en", 32'(ram_wr_en), 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    step(); idle(); rst_n = 1;

    // single read by m0
    m0_req = 1; m0_addr = 32'h40; #2;
    chk("rd_m0_gnt", 32'(m0_gnt), 1);
    chk("rd_m1_gnt", 32'(m1_gnt), 0);
    chk("rd_ram_addr", ram_addr, 32'h40);
    step(); idle(); #2;
    chk("rd_m0_rvalid", 32'(m0_rvalid), 1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", 32'(m1_rvalid), 0);
    step(); #2;
    chk("rd_m0_rvalid_drop", 32'(m0_rvalid), 0);
    chk("rd_m0_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // m1 write alone, leaving m1 as last granted
    step();
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'hA5A5A5A5; #2;
    chk("wr_m1_gnt", 32'(m1_gnt), 1);
    chk("wr_en", 32'(ram_wr_en), 1);
    step();

    // round robin, both reading
    idle(); m0_req = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h44;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("rr_m0_gnt", 32'(m0_gnt), 32'(i % 2 == 0));
      chk("rr_m1_gnt", 32'(m1_gnt), 32'(i % 2 == 1));
      step();
    end
    idle(); step();

    // bounded lock: m1 locked writes, m0 reading from the second cycle
    for (int c = 0; c < 9; c++) begin
      k = (c < 4) ? c : c - 1;
      m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h100 + 32'(4 * k); m1_wdata = 32'hC0DE0000 + 32'(k);
      m0_req = (c >= 1 && c <= 4); m0_we = 0; m0_addr = 32'h40;
      #2;
      chk("lk_m1_gnt", 32'(m1_gnt), 32'(c != 4));
      chk("lk_m0_gnt", 32'(m0_gnt), 32'(c == 4));
      step();
    end
    idle(); step();
    for (int j = 0; j < 8; j++) chk("lk_mem", mem[8'h40 + 8'(j)], 32'hC0DE0000 + 32'(j));

    // lock without contention, then m1 arrives
    for (int c = 0; c < 20; c++) begin
      m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 32'h300 + 32'(4 * c); m0_wdata = 32'hB0000000 + 32'(c);
      #2;
      chk("solo_m0_gnt", 32'(m0_gnt), 1);
      step();
    end
    gi = -1; n0 = 20;
    for (int j = 0; j < 6; j++) begin
      m0_req = (gi < 0); m0_we = 1; m0_lock = 1; m0_addr = 32'h300 + 32'(4 * n0); m0_wdata = 32'hB0000000 + 32'(n0);
      m1_req = (gi < 0); m1_we = 0; m1_addr = 32'h300;
      #2;
      if (m0_gnt) n0++;
      if (m1_gnt && gi < 0) gi = j;
      step();
    end
    chk("starve_m1_gnt_cycle", 32'(gi), 32'd3);
    idle(); step();

    // same-address write/read, last = m1
    m0_req = 1; m0_we = 1; m0_addr = 32'h8; m0_wdata = 32'h12345678;
    m1_req = 1; m1_we = 0; m1_addr = 32'h8; #2;
    chk("ws_m0_gnt", 32'(m0_gnt), 1);
    chk("ws_m1_gnt", 32'(m1_gnt), 0);
    step();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; #2;
    chk("ws_m1_gnt2", 32'(m1_gnt), 1);
    chk("ws_mem", mem[2], 32'h12345678);
    step(); idle(); #2;
    chk("ws_m1_rvalid", 32'(m1_rvalid), 1);
    chk("ws_m1_rdata", m1_rdata, 32'h12345678);

    // reset in the middle of a read return
    step();
    m1_req = 1; m1_addr = 32'h40; #2;
    chk("rr2_m1_gnt", 32'(m1_gnt), 1);
    step(); idle(); #2;
    chk("rr2_m1_rvalid", 32'(m1_rvalid), 1);
    rst_n = 0;
    m0_req = 1; m0_we = 1; m0_addr = 32'h80; m0_wdata = 32'h77;
    m1_req = 1; m1_we = 1; m1_addr = 32'h84; m1_wdata = 32'h88; #1;
    chk("ar_m1_rvalid", 32'(m1_rvalid), 0);
    chk("ar_m1_rdata", m1_rdata, 0);
    chk("ar_m0_gnt", 32'(m0_gnt), 0);
    chk("ar_m1_gnt", 32'(m1_gnt), 0);
    chk("ar_wr_en", 32'(ram_wr_en), 0);
    step(); step();
    m0_we = 0; m1_we = 0; rst_n = 1; #2;
    chk("ar_tie_m0", 32'(m0_gnt), 1);
    chk("ar_tie_m1", 32'(m1_gnt), 0);
    step(); idle(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
